// File: rtl/line_scaler_scheduler.sv
// Read-side sequencer for the ping-pong line buffer: horizontal fixed-point address
// stepping, vertical line repeat, bank swap decisions and underrun/collision debug counters.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for the first frame start after reset
// S_WAIT   | frame running, no bank adopted yet; swaps once one is ready
// S_ACTIVE | displaying rd_bank, repeating each line LINE_REPEAT times
module line_scaler_scheduler #(
    parameter int SRC_WIDTH   = 720,
    parameter int DST_WIDTH   = 1280,
    parameter int ADDR_W      = 11,
    parameter int FRAC_W      = 16,
    parameter int LINE_REPEAT = 3,
    parameter int RAM_LAT     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_start,
    input  logic              frame_start,
    input  logic              data_req,
    input  logic              wr_line_done,
    input  logic              wr_bank,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              pix_valid,
    output logic [1:0]        rep_cnt,
    output logic [7:0]        underrun_cnt,
    output logic              collision
);

    localparam int ACC_W = ADDR_W + FRAC_W;
    localparam longint STEP_L = (longint'(SRC_WIDTH) << FRAC_W) / longint'(DST_WIDTH);
    localparam logic [ACC_W-1:0]  STEP     = ACC_W'(STEP_L);
    localparam logic [ADDR_W-1:0] SRC_LAST = ADDR_W'(SRC_WIDTH - 1);
    localparam logic [1:0]        REP_LAST = 2'(LINE_REPEAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACTIVE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        ready;
    logic [1:0]        ready_nxt;
    logic              rd_bank_nxt;
    logic [1:0]        rep_nxt;
    logic [7:0]        under_nxt;
    logic              coll_nxt;
    logic              swap;

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_base;
    logic [ADDR_W-1:0] acc_int;
    logic [ADDR_W-1:0] addr_clamped;
    logic [RAM_LAT:0]  pv_sr;

    // Horizontal stepping: a line start restarts the accumulator, even with a
    // request in the same cycle.
    always_comb begin
        acc_base     = line_start ? '0 : acc;
        acc_int      = acc_base[ACC_W-1:FRAC_W];
        addr_clamped = (acc_int > SRC_LAST) ? SRC_LAST : acc_int;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc     <= '0;
            rd_addr <= '0;
            pv_sr   <= '0;
        end else begin
            pv_sr <= {pv_sr[RAM_LAT-1:0], data_req};
            if (data_req) begin
                rd_addr <= addr_clamped;
                acc     <= acc_base + STEP;
            end else begin
                acc <= acc_base;
            end
        end
    end

    assign pix_valid = pv_sr[RAM_LAT];

    always_comb begin
        state_nxt   = state;
        rd_bank_nxt = rd_bank;
        rep_nxt     = rep_cnt;
        under_nxt   = underrun_cnt;
        coll_nxt    = collision;
        ready_nxt   = ready;
        swap        = 1'b0;

        case (state)
            S_IDLE: begin
                if (frame_start) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (line_start && ready[~rd_bank]) begin
                    swap      = 1'b1;
                    rep_nxt   = 2'd0;
                    state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                // Frame start always closes the current source line.
                if (frame_start || (line_start && rep_cnt >= REP_LAST)) begin
                    rep_nxt = 2'd0;
                    if (ready[~rd_bank]) begin
                        swap = 1'b1;
                    end else if (underrun_cnt != 8'hFF) begin
                        under_nxt = underrun_cnt + 8'd1;
                    end
                end else if (line_start) begin
                    rep_nxt = rep_cnt + 2'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (swap) begin
            rd_bank_nxt         = ~rd_bank;
            ready_nxt[~rd_bank] = 1'b0;
        end

        // During a swap either bank finishing is a fresh line: the adopted bank
        // keeps its ready bit, the old bank is judged against the new rd_bank.
        if (wr_line_done) begin
            if (swap || (wr_bank != rd_bank)) begin
                ready_nxt[wr_bank] = 1'b1;
            end else begin
                coll_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            rd_bank      <= 1'b0;
            rep_cnt      <= 2'd0;
            underrun_cnt <= 8'd0;
            collision    <= 1'b0;
            ready        <= 2'b00;
        end else begin
            state        <= state_nxt;
            rd_bank      <= rd_bank_nxt;
            rep_cnt      <= rep_nxt;
            underrun_cnt <= under_nxt;
            collision    <= coll_nxt;
            ready        <= ready_nxt;
        end
    end

endmodule
